// File: rtl/pc_redirect_ctrl_pkg.sv
// rtl/pc_redirect_ctrl_pkg.sv - shared encodings and types for the PC redirect controller
package pc_redirect_ctrl_pkg;

  localparam logic [2:0] IS_NONE      = 3'd0;
  localparam logic [2:0] IS_EXCEPTION = 3'd1;
  localparam logic [2:0] IS_ERET      = 3'd2;
  localparam logic [2:0] IS_REFETCH   = 3'd3;

  localparam int HOLD_CNT_W = 3;

  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} redirect_state_e;
  typedef enum logic {BRANCH, EXCEPT} redirect_kind_e;

endpackage

// File: rtl/pc_redirect_ctrl_evt_counter.sv
// rtl/pc_redirect_ctrl_evt_counter.sv - wrapping event counter with increment enable
module redirect_evt_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - arbitrates exception/branch redirects toward IF and drives stage flushes
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int FLUSH_HOLD = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [2:0]       EX_Entry_Sel,
  input  logic [31:0]      Exception_Vector,
  input  logic             Flush_Exception,
  input  logic [31:0]      MEM_PC,
  input  logic             MEM_Valid,
  input  logic             MEM_Stall,
  input  logic [31:0]      CP0_EPC,
  input  logic             EX_BranchTaken,
  input  logic [31:0]      EX_BranchTarget,
  input  logic             IF_RedirectReady,
  output logic             Redirect_Valid,
  output logic [31:0]      Redirect_PC,
  output logic             Flush_IF,
  output logic             Flush_ID,
  output logic             Flush_EX,
  output logic             Flush_MEM,
  output logic             CP0_Commit,
  output logic             Busy,
  output logic [CNT_W-1:0] ExcCnt,
  output logic [CNT_W-1:0] EretCnt,
  output logic [CNT_W-1:0] RefetchCnt
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_INIT = HOLD_CNT_W'(FLUSH_HOLD);

  redirect_state_e           state;
  redirect_kind_e            kind;
  logic [HOLD_CNT_W-1:0]     hold_cnt;
  logic                      trig;
  logic                      br_req;
  logic                      redirecting;
  logic [31:0]               exc_target;

  // Exception-class requests win over a same-cycle branch: the branch is younger.
  assign trig   = resetn && (state == IDLE) && Flush_Exception && MEM_Valid &&
                  !MEM_Stall && (EX_Entry_Sel != IS_NONE);
  assign br_req = resetn && (state == IDLE) && !trig && EX_BranchTaken && !MEM_Stall;

  always_comb begin
    exc_target = Exception_Vector;
    case (EX_Entry_Sel)
      IS_ERET:    exc_target = CP0_EPC;
      IS_REFETCH: exc_target = MEM_PC;
      default:    exc_target = Exception_Vector;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      kind           <= BRANCH;
      hold_cnt       <= '0;
      Redirect_Valid <= 1'b0;
      Redirect_PC    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state          <= HOLD;
            kind           <= EXCEPT;
            Redirect_Valid <= 1'b1;
            Redirect_PC    <= exc_target;
          end else if (br_req) begin
            state          <= HOLD;
            kind           <= BRANCH;
            Redirect_Valid <= 1'b1;
            Redirect_PC    <= EX_BranchTarget;
          end
        end
        HOLD: begin
          if (IF_RedirectReady) begin
            state          <= FLUSH;
            Redirect_Valid <= 1'b0;
            hold_cnt       <= HOLD_INIT;
          end
        end
        FLUSH: begin
          if (hold_cnt == HOLD_CNT_W'(1)) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HOLD_CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Once redirecting, fetch is flushed until the icache drain window closes.
  assign redirecting = (state == HOLD) || (state == FLUSH);
  assign Flush_IF    = redirecting;
  assign Flush_ID    = (redirecting && (kind == EXCEPT)) || br_req;
  assign Flush_EX    = trig;
  assign Flush_MEM   = trig;
  assign CP0_Commit  = trig && (EX_Entry_Sel != IS_REFETCH);
  assign Busy        = (state != IDLE);

  redirect_evt_counter #(.CNT_W(CNT_W)) u_exc_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (trig && (EX_Entry_Sel == IS_EXCEPTION)),
    .count  (ExcCnt)
  );

  redirect_evt_counter #(.CNT_W(CNT_W)) u_eret_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (trig && (EX_Entry_Sel == IS_ERET)),
    .count  (EretCnt)
  );

  redirect_evt_counter #(.CNT_W(CNT_W)) u_refetch_cnt (
    .clk    (clk),
    .resetn (resetn),
    .inc    (trig && (EX_Entry_Sel == IS_REFETCH)),
    .count  (RefetchCnt)
  );

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sits directly downstream of the MEM-stage exception unit and upstream of the IF-stage PC register.
- Consumes the entry select, exception vector and flush request; registers one redirect and holds it until fetch accepts it.
- Generates the flush pulses for IF/ID/EX/MEM and arbitrates exception redirects against EX-stage branch redirects.
- Counts committed exceptions, erets and refetches for debug.

Parameters:
- FLUSH_HOLD, 2, cycles the IF/ID flush stays asserted after a redirect is accepted (drains in-flight icache responses); legal range 1..7.
- CNT_W, 32, width of the event counters.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- EX_Entry_Sel  in  3  IsNone/IsException/IsEret/IsRefetch, from the exception unit
- Exception_Vector  in  32  exception entry address
- Flush_Exception  in  1  MEM-stage exception/eret/refetch present
- MEM_PC  in  32  PC of the MEM instruction
- MEM_Valid  in  1  MEM slot holds a real instruction
- MEM_Stall  in  1  MEM stage frozen this cycle
- CP0_EPC  in  32  current EPC
- EX_BranchTaken  in  1  EX branch/jump mispredict redirect request
- EX_BranchTarget  in  32  branch target
- IF_RedirectReady  in  1  fetch can accept a new PC this cycle
- Redirect_Valid  out  1  redirect pending toward IF
- Redirect_PC  out  32  redirect target
- Flush_IF, Flush_ID, Flush_EX, Flush_MEM  out  1 each  stage flushes
- CP0_Commit  out  1  one-cycle pulse: CP0 latches EPC/Cause/EXL (exceptions) or clears EXL (eret)
- Busy  out  1  state != IDLE
- ExcCnt, EretCnt, RefetchCnt  out  CNT_W each  event counters

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE; every output 0; counters 0; Redirect_PC=0. Reset mid-HOLD/FLUSH drops the pending redirect silently.
- Trigger: `trig = Flush_Exception & MEM_Valid & ~MEM_Stall & EX_Entry_Sel!=IsNone`, evaluated only in IDLE.
- Target select:
  - IsException -> Exception_Vector
  - IsEret -> CP0_EPC, sampled in the trigger cycle
  - IsRefetch -> MEM_PC, sampled in the trigger cycle
- Trigger cycle (combinational in the same cycle):
  - Flush_EX=1 and Flush_MEM=1.
  - CP0_Commit=1 for IsException and IsEret; 0 for IsRefetch.
  - The matching counter increments at the next edge, wrapping at 2^CNT_W.
- States:
  - IDLE, trig -> HOLD: Redirect_PC<=target, Redirect_Valid<=1 at the next edge.
  - IDLE, ~trig & EX_BranchTaken & ~MEM_Stall -> HOLD: target=EX_BranchTarget; no CP0_Commit, no counter update; Flush_ID=1 in the request cycle only.
  - IDLE, trig & EX_BranchTaken in the same cycle -> exception wins and the branch is dropped (it is younger).
  - HOLD: Redirect_Valid=1, Redirect_PC stable.
    - Flush_IF=Flush_ID=1 every HOLD cycle for exception-class redirects; for branch-class redirects only Flush_IF=1.
    - Handshake completes on IF_RedirectReady=1 -> FLUSH and Redirect_Valid<=0.
    - All new trig / EX_BranchTaken are ignored; upstream is flushed, so they are stale.
  - FLUSH: Flush_IF=1; Flush_ID=1 only for exception-class redirects; down-counter loaded with FLUSH_HOLD.
    - Counter==1 -> IDLE.
    - A trig in FLUSH is not legal; the bench asserts it never occurs.
- Latency: trigger edge to Redirect_Valid = 1 cycle. With IF_RedirectReady tied high: HOLD lasts 1 cycle, then FLUSH_HOLD cycles, so back in IDLE after 2+FLUSH_HOLD cycles.
- MEM_Stall=1 blocks both trigger types; the trigger is re-evaluated every cycle until the stall lifts.
- Busy = (state!=IDLE).

Decomposition:
- Shared header/package holds:
  - EX_Entry_Sel encodings: IsNone=3'd0, IsException=3'd1, IsEret=3'd2, IsRefetch=3'd3.
  - A redirect_state enum {IDLE, HOLD, FLUSH}.
  - A RedirectKind type {BRANCH, EXCEPT}.
- One sub-module is natural: redirect_evt_counter, a CNT_W wrapping counter with inc enable, instantiated three times.

Test Plan:
- Exception, fetch ready: IsException, Exception_Vector=0xBFC00380, IF_RedirectReady=1 ->
  - trigger cycle: CP0_Commit=1, Flush_EX=Flush_MEM=1.
  - next cycle: Redirect_Valid=1, Redirect_PC=0xBFC00380.
  - IDLE after 2+FLUSH_HOLD=4 cycles; ExcCnt=1.
- Eret, fetch stalled: IsEret, CP0_EPC=0x80001234, IF_RedirectReady=0 for 5 cycles ->
  - Redirect_Valid holds 5 cycles with PC stable at 0x80001234.
  - Flush_IF/ID high throughout; EretCnt=1.
- Refetch: IsRefetch, MEM_PC=0x8000_0100 ->
  - Redirect_PC=0x80000100, CP0_Commit=0.
  - RefetchCnt=1, ExcCnt unchanged.
- Same-cycle conflict: IsException plus EX_BranchTaken (target 0x80002000) ->
  - Redirect_PC=Exception_Vector; the branch never appears.
  - Also: a branch arriving during HOLD is ignored.
- Stall gating and reset:
  - MEM_Stall=1 with an exception pending for 3 cycles -> no outputs; trigger fires on the first unstalled cycle.
  - resetn=0 during HOLD -> next cycle all outputs 0, state IDLE.
- Wrap: CNT_W=4, 16 exceptions -> ExcCnt returns to 0.
